// File: rtl/fetch_stage.sv
// fetch_stage: barrel-threaded instruction fetch with round-robin thread select,
// synchronous imem read and a one-entry skid buffer absorbing decode stalls.
module fetch_stage #(
    parameter int INSTR_WIDTH       = 32,
    parameter int THREAD_INDEX_BITS = 3,
    parameter int PC_WIDTH          = 16,
    parameter int RESET_PC          = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_stall,
    input  logic [2**THREAD_INDEX_BITS-1:0] in_thread_enable_mask,
    input  logic                            in_redirect_flag,
    input  logic [THREAD_INDEX_BITS-1:0]    in_redirect_thread_index,
    input  logic [PC_WIDTH-1:0]             in_redirect_pc,
    output logic                            imem_en,
    output logic [PC_WIDTH-1:0]             imem_addr,
    input  logic [INSTR_WIDTH-1:0]          imem_rdata,
    output logic [INSTR_WIDTH-1:0]          out_instruction,
    output logic [THREAD_INDEX_BITS-1:0]    out_thread_index,
    output logic                            out_valid
);
    localparam int NUM_THREADS = 2**THREAD_INDEX_BITS;

    logic [PC_WIDTH-1:0]          pc [NUM_THREADS];
    logic [THREAD_INDEX_BITS-1:0] last_thread;
    logic [THREAD_INDEX_BITS-1:0] resp_thread;
    logic [THREAD_INDEX_BITS-1:0] skid_thread;
    logic [THREAD_INDEX_BITS-1:0] sel;
    logic [INSTR_WIDTH-1:0]       skid_instruction;
    logic                         resp_valid;
    logic                         skid_full;
    logic                         found;
    logic                         issue;

    // Scan from farthest to nearest so the nearest enabled thread after last_thread wins.
    always_comb begin
        sel = last_thread;
        found = 1'b0;
        for (int i = NUM_THREADS; i >= 1; i--) begin
            if (in_thread_enable_mask[THREAD_INDEX_BITS'(last_thread + THREAD_INDEX_BITS'(i))]) begin
                sel = THREAD_INDEX_BITS'(last_thread + THREAD_INDEX_BITS'(i));
                found = 1'b1;
            end
        end
    end

    assign issue     = !rst && !in_stall && !skid_full && found;
    assign imem_en   = issue;
    assign imem_addr = pc[sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_THREADS; i++) pc[i] <= PC_WIDTH'(RESET_PC);
            last_thread      <= THREAD_INDEX_BITS'(NUM_THREADS - 1);
            resp_thread      <= '0;
            resp_valid       <= 1'b0;
            skid_full        <= 1'b0;
            skid_instruction <= '0;
            skid_thread      <= '0;
            out_valid        <= 1'b0;
            out_instruction  <= '0;
            out_thread_index <= '0;
        end else begin
            resp_valid <= issue;
            if (issue) begin
                pc[sel]     <= pc[sel] + 1'b1;
                last_thread <= sel;
                resp_thread <= sel;
            end
            // Redirect is written after the increment so it wins on the same thread.
            if (in_redirect_flag) pc[in_redirect_thread_index] <= in_redirect_pc;
            if (!in_stall) begin
                if (skid_full) begin
                    out_instruction  <= skid_instruction;
                    out_thread_index <= skid_thread;
                    out_valid        <= 1'b1;
                    skid_full        <= 1'b0;
                end else if (resp_valid) begin
                    out_instruction  <= imem_rdata;
                    out_thread_index <= resp_thread;
                    out_valid        <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (resp_valid) begin
                skid_instruction <= imem_rdata;
                skid_thread      <= resp_thread;
                skid_full        <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random and directed stimulus against a timestamped-queue model of the fetch stage.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_stall = 1'b0;
    logic [7:0]  in_thread_enable_mask = 8'hFF;
    logic        in_redirect_flag = 1'b0;
    logic [2:0]  in_redirect_thread_index = 3'd0;
    logic [15:0] in_redirect_pc = 16'h0;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] out_instruction;
    logic [2:0]  out_thread_index;
    logic        out_valid;

    int vectors = 0;
    int miscompares = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .in_stall(in_stall),
        .in_thread_enable_mask(in_thread_enable_mask),
        .in_redirect_flag(in_redirect_flag),
        .in_redirect_thread_index(in_redirect_thread_index),
        .in_redirect_pc(in_redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_instruction(out_instruction), .out_thread_index(out_thread_index),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [15:0] a);
        return {a ^ 16'hA5A5, a};
    endfunction

    // Read data is only meaningful the cycle after a request; otherwise it is noise.
    always @(posedge clk) imem_rdata <= imem_en ? mem_f(imem_addr) : $urandom;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic [2:0]  th;
        int          t;
    } ent_t;

    ent_t        q[$];
    int          now = 0;
    logic [15:0] m_pc[8];
    logic [2:0]  m_last = 3'd7;
    logic        e_valid = 1'b0;
    logic [31:0] e_instr = 32'h0;
    logic [2:0]  e_th = 3'd0;

    initial for (int k = 0; k < 8; k++) m_pc[k] = 16'h0;

    // Model: an issued item becomes deliverable the cycle after issue; one left
    // undelivered past that occupies the skid and blocks further issue.
    always @(negedge clk) begin
        logic       skid;
        logic       found;
        logic       en;
        logic [2:0] s;
        ent_t       e;
        skid = q.size() > 0 && q[0].t < now - 1;
        found = 1'b0;
        s = 3'd0;
        for (int k = 1; k <= 8; k++)
            if (!found && in_thread_enable_mask[(int'(m_last) + k) % 8]) begin
                found = 1'b1;
                s = 3'((int'(m_last) + k) % 8);
            end
        en = !rst && !in_stall && !skid && found;
        chk("imem_en", {31'b0, imem_en}, {31'b0, en});
        if (en) chk("imem_addr", {16'b0, imem_addr}, {16'b0, m_pc[s]});
        chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
        chk("out_instruction", out_instruction, e_instr);
        chk("out_thread_index", {29'b0, out_thread_index}, {29'b0, e_th});
        if (rst) begin
            q.delete();
            for (int k = 0; k < 8; k++) m_pc[k] = 16'h0;
            m_last = 3'd7;
            e_valid = 1'b0;
            e_instr = 32'h0;
            e_th = 3'd0;
        end else begin
            if (!in_stall) begin
                if (q.size() > 0 && q[0].t < now) begin
                    e = q.pop_front();
                    e_valid = 1'b1;
                    e_instr = e.d;
                    e_th = e.th;
                end else e_valid = 1'b0;
            end
            if (en) begin
                q.push_back('{mem_f(m_pc[s]), s, now});
                m_pc[s] = m_pc[s] + 16'h1;
                m_last = s;
            end
            if (in_redirect_flag) m_pc[in_redirect_thread_index] = in_redirect_pc;
        end
        now++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("release_en", {31'b0, imem_en}, 32'd1);
        chk("release_addr", {16'b0, imem_addr}, 32'h0);
        step();
        step();
        #1;
        chk("first_valid", {31'b0, out_valid}, 32'd1);
        chk("first_thread", {29'b0, out_thread_index}, 32'd0);
        chk("first_instr", out_instruction, 32'hA5A50000);
        repeat (20) step();
        in_thread_enable_mask = 8'h24;
        repeat (10) step();
        in_thread_enable_mask = 8'h00;
        #1;
        chk("mask0_en", {31'b0, imem_en}, 32'd0);
        repeat (5) step();
        in_thread_enable_mask = 8'h24;
        repeat (6) step();
        in_thread_enable_mask = 8'hFF;
        repeat (5) step();
        in_stall = 1'b1;
        #1;
        chk("stall_en", {31'b0, imem_en}, 32'd0);
        step();
        step();
        in_stall = 1'b0;
        repeat (10) step();

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        in_thread_enable_mask = 8'h08;
        repeat (5) step();
        in_redirect_flag = 1'b1;
        in_redirect_thread_index = 3'd3;
        in_redirect_pc = 16'h0040;
        #1;
        chk("redir_issue_addr", {16'b0, imem_addr}, 32'h5);
        step();
        in_redirect_flag = 1'b0;
        #1;
        chk("redir_next_addr", {16'b0, imem_addr}, 32'h40);
        step();
        #1;
        chk("redir_inflight_instr", out_instruction, 32'hA5A00005);
        chk("redir_inflight_thread", {29'b0, out_thread_index}, 32'd3);

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        in_thread_enable_mask = 8'h01;
        in_redirect_flag = 1'b1;
        in_redirect_thread_index = 3'd0;
        in_redirect_pc = 16'hFFFF;
        #1;
        chk("wrap_addr0", {16'b0, imem_addr}, 32'h0);
        step();
        in_redirect_flag = 1'b0;
        #1;
        chk("wrap_addr1", {16'b0, imem_addr}, 32'hFFFF);
        step();
        #1;
        chk("wrap_addr2", {16'b0, imem_addr}, 32'h0);
        step();
        #1;
        chk("wrap_addr3", {16'b0, imem_addr}, 32'h1);

        in_thread_enable_mask = 8'hFF;
        repeat (4) step();
        in_stall = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_stall = 1'b0;
        #1;
        chk("rst_skid_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_skid_addr", {16'b0, imem_addr}, 32'h0);
        step();
        step();
        #1;
        chk("rst_skid_first_thread", {29'b0, out_thread_index}, 32'd0);
        chk("rst_skid_first_valid", {31'b0, out_valid}, 32'd1);

        for (int n = 0; n < 3000; n++) begin
            step();
            rst = ($urandom % 100) == 0;
            in_stall = ($urandom % 4) == 0;
            in_thread_enable_mask = ($urandom % 8 == 0) ? 8'h00 :
                                    ($urandom % 3 == 0) ? 8'hFF : 8'($urandom);
            in_redirect_flag = ($urandom % 8) == 0;
            in_redirect_thread_index = 3'($urandom);
            in_redirect_pc = ($urandom % 2) ? 16'($urandom) : 16'hFFFE + 16'($urandom % 2);
        end
        rst = 1'b0;
        in_stall = 1'b0;
        in_redirect_flag = 1'b0;
        in_thread_enable_mask = 8'hFF;
        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
